// File: rtl/sdram_pkg.sv
// Shared SDRAM arbiter definitions: pin command encodings, FSM state encoding and
// the auto-refresh address (A10 high selects all banks).
package sdram_pkg;

  // {CKE, CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [4:0] CMD_NOP  = 5'b10111;
  localparam logic [4:0] CMD_PREC = 5'b10010;
  localparam logic [4:0] CMD_AREF = 5'b10001;
  localparam logic [4:0] CMD_MRS  = 5'b10000;

  localparam logic [11:0] AREF_ADDR = 12'h400;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh period timer: starts once init is done, raises ref_req on each wrap
// and flags ref_overrun when a wrap finds the previous request still unserved.
module sdram_ref_timer #(
  parameter int REF_PERIOD = 780,
  parameter int CNT_W      = 10
) (
  input  logic S_CLK,
  input  logic RST_N,
  input  logic flag_init,
  input  logic ref_clr,
  output logic ref_req,
  output logic ref_overrun
);

  logic [CNT_W-1:0] cnt;
  logic             running;
  logic             run_en;
  logic             wrap;

  // Once started the timer ignores flag_init, so a late drop cannot stall refresh.
  assign run_en = flag_init | running;
  assign wrap   = run_en && (cnt == CNT_W'(REF_PERIOD - 1));

  // NOTE: every register here uses non-blocking assignment so all updates see
  // the pre-edge values of cnt and ref_req, regardless of statement order.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt         <= '0;
      running     <= 1'b0;
      ref_req     <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      if (flag_init) running <= 1'b1;
      if (run_en)    cnt     <= wrap ? '0 : cnt + 1'b1;
      // Clear beats a coincident wrap; that lost request is reported as an overrun.
      if (ref_clr)   ref_req <= 1'b0;
      else if (wrap) ref_req <= 1'b1;
      if (wrap && ref_req) ref_overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command/address bus owner: init pass-through, periodic auto-refresh and
// one-burst-at-a-time grants to the write/read engines. Define SDRAM_ARB_RR_EN
// for round-robin write/read arbitration (default: write beats read).
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = 780,
  parameter int T_RC       = 7,
  parameter int CNT_W      = 10
) (
  input  logic        S_CLK,
  input  logic        RST_N,
  input  logic        flag_init,
  input  logic [4:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        wr_req,
  input  logic [4:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_ba,
  input  logic        wr_end,
  output logic        wr_en,
  input  logic        rd_req,
  input  logic [4:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_ba,
  input  logic        rd_end,
  output logic        rd_en,
  output logic        ref_pending,
  output logic [4:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_ba,
  output logic        ref_overrun
);

  localparam int STEP_W = (T_RC > 1) ? $clog2(T_RC) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [STEP_W-1:0] step;
  logic              aref_last;
  logic              ref_req;
  logic              ref_clr;
  logic              pick_wr;

  assign aref_last   = (step == STEP_W'(T_RC - 1));
  assign ref_clr     = (state == ST_AREF) && (step == '0);
  assign ref_pending = ref_req;

  sdram_ref_timer #(
    .REF_PERIOD (REF_PERIOD),
    .CNT_W      (CNT_W)
  ) u_ref_timer (
    .S_CLK       (S_CLK),
    .RST_N       (RST_N),
    .flag_init   (flag_init),
    .ref_clr     (ref_clr),
    .ref_req     (ref_req),
    .ref_overrun (ref_overrun)
  );

`ifdef SDRAM_ARB_RR_EN
  logic last_wr;

  // On a write/read tie the side not served last wins; write wins the first tie.
  assign pick_wr = wr_req && !(rd_req && last_wr);

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_wr <= 1'b0;
    end else if (state == ST_ARBIT) begin
      if (state_nxt == ST_WRITE)     last_wr <= 1'b1;
      else if (state_nxt == ST_READ) last_wr <= 1'b0;
    end
  end
`else
  assign pick_wr = wr_req;
`endif

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_INIT;
      step  <= '0;
      wr_en <= 1'b0;
      rd_en <= 1'b0;
    end else begin
      state <= state_nxt;
      step  <= (state == ST_AREF && !aref_last) ? step + 1'b1 : '0;
      // Grants are registered from the next state: they rise on the edge leaving
      // ARBIT and fall on the edge that consumes the end pulse.
      wr_en <= (state_nxt == ST_WRITE);
      rd_en <= (state_nxt == ST_READ);
    end
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT:  if (flag_init) state_nxt = ST_ARBIT;
      ST_ARBIT: begin
        if (ref_req)      state_nxt = ST_AREF;
        else if (pick_wr) state_nxt = ST_WRITE;
        else if (rd_req)  state_nxt = ST_READ;
      end
      ST_AREF:  if (aref_last) state_nxt = ST_ARBIT;
      ST_WRITE: if (wr_end)    state_nxt = ST_ARBIT;
      ST_READ:  if (rd_end)    state_nxt = ST_ARBIT;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_ba   = '0;
    unique case (state)
      ST_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        if (step == '0) begin
          sdram_cmd  = CMD_AREF;
          sdram_addr = AREF_ADDR;
        end
      end
      ST_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_ba   = wr_ba;
      end
      ST_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_ba   = rd_ba;
      end
      default: ;
    endcase
    // Pins sit at NOP while reset is asserted, whatever the init block drives.
    if (!RST_N) begin
      sdram_cmd  = CMD_NOP;
      sdram_addr = '0;
      sdram_ba   = '0;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: expected output records are queued as
// stimulus is driven and compared against the pins on the following falling edge.
`timescale 1ns/1ps
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int REF_PERIOD = 780;
  localparam int T_RC       = 7;

  // Output vector layout: {cmd[4:0], addr[11:0], ba[1:0], wr_en, rd_en, ref_pending, ref_overrun}
  localparam logic [22:0] M_ALL  = '1;
  localparam logic [22:0] M_PIN  = {19'h7ffff, 4'b0000};
  localparam logic [22:0] M_GNT  = {19'h0, 4'b1100};
  localparam logic [22:0] M_PEND = {19'h0, 4'b0010};
  localparam logic [22:0] M_OVR  = {19'h0, 4'b0001};

  logic        S_CLK = 1'b0;
  logic        RST_N;
  logic        flag_init;
  logic [4:0]  init_cmd;
  logic [11:0] init_addr;
  logic        wr_req, wr_end, wr_en;
  logic [4:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  wr_ba;
  logic        rd_req, rd_end, rd_en;
  logic [4:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_ba;
  logic        ref_pending, ref_overrun;
  logic [4:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_ba;

  sdram_arbiter #(
    .REF_PERIOD (REF_PERIOD),
    .T_RC       (T_RC),
    .CNT_W      (10)
  ) dut (
    .S_CLK       (S_CLK),
    .RST_N       (RST_N),
    .flag_init   (flag_init),
    .init_cmd    (init_cmd),
    .init_addr   (init_addr),
    .wr_req      (wr_req),
    .wr_cmd      (wr_cmd),
    .wr_addr     (wr_addr),
    .wr_ba       (wr_ba),
    .wr_end      (wr_end),
    .wr_en       (wr_en),
    .rd_req      (rd_req),
    .rd_cmd      (rd_cmd),
    .rd_addr     (rd_addr),
    .rd_ba       (rd_ba),
    .rd_end      (rd_end),
    .rd_en       (rd_en),
    .ref_pending (ref_pending),
    .sdram_cmd   (sdram_cmd),
    .sdram_addr  (sdram_addr),
    .sdram_ba    (sdram_ba),
    .ref_overrun (ref_overrun)
  );

  always #5 S_CLK = ~S_CLK;

  typedef struct {
    string       name;
    logic [22:0] exp;
    logic [22:0] mask;
  } sb_t;

  typedef struct {
    logic [4:0]  a_cmd;
    logic [11:0] a_addr;
    logic [1:0]  a_ba;
    logic [4:0]  o_cmd;
    logic [11:0] o_addr;
    logic [1:0]  o_ba;
    logic        stray_end;
    logic [4:0]  e_cmd;
    logic [11:0] e_addr;
    logic [1:0]  e_ba;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   t0;
  int   t1;

  function automatic logic [22:0] mk(input logic [4:0] c, input logic [11:0] a, input logic [1:0] b,
                                     input logic w, input logic r, input logic p, input logic o);
    return {c, a, b, w, r, p, o};
  endfunction

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp,
                       input logic [22:0] mask);
    n_checks++;
    if ((act & mask) == (exp & mask)) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h, expected %h (mask %h)",
                  name, cyc, act & mask, exp & mask, mask);
  endtask

  task automatic chk(input string name, input logic [22:0] exp, input logic [22:0] mask);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    e.mask = mask;
    sb_q.push_back(e);
  endtask

  always @(negedge S_CLK) begin
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, {sdram_cmd, sdram_addr, sdram_ba, wr_en, rd_en, ref_pending, ref_overrun},
            e.exp, e.mask);
    end
  end

  task automatic step();
    @(posedge S_CLK);
    cyc++;
    #1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  // Drive the table on the granted side, noise plus stray end pulses on the other.
  task automatic apply_vecs(input logic is_wr, input string tag);
    for (int i = 0; i < 6; i++) begin
      if (is_wr) begin
        wr_cmd = vecs[i].a_cmd; wr_addr = vecs[i].a_addr; wr_ba = vecs[i].a_ba;
        rd_cmd = vecs[i].o_cmd; rd_addr = vecs[i].o_addr; rd_ba = vecs[i].o_ba;
        rd_end = vecs[i].stray_end;
      end else begin
        rd_cmd = vecs[i].a_cmd; rd_addr = vecs[i].a_addr; rd_ba = vecs[i].a_ba;
        wr_cmd = vecs[i].o_cmd; wr_addr = vecs[i].o_addr; wr_ba = vecs[i].o_ba;
        wr_end = vecs[i].stray_end;
      end
      chk(tag, mk(vecs[i].e_cmd, vecs[i].e_addr, vecs[i].e_ba, is_wr, !is_wr, 1'b0, 1'b0), M_ALL);
      step();
    end
    wr_end = 1'b0;
    rd_end = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [4:0] init_pat [4];
    logic       exp_wr;

    vecs[0] = '{5'b10100, 12'h000, 2'd0, 5'b10101, 12'hfff, 2'd3, 1'b0, 5'b10100, 12'h000, 2'd0};
    vecs[1] = '{5'b10111, 12'h3ff, 2'd1, 5'b10000, 12'h001, 2'd2, 1'b1, 5'b10111, 12'h3ff, 2'd1};
    vecs[2] = '{5'b10011, 12'h400, 2'd2, 5'b10010, 12'h555, 2'd0, 1'b0, 5'b10011, 12'h400, 2'd2};
    vecs[3] = '{5'b10100, 12'hfff, 2'd3, 5'b10101, 12'h0aa, 2'd1, 1'b1, 5'b10100, 12'hfff, 2'd3};
    vecs[4] = '{5'b00111, 12'h800, 2'd1, 5'b10111, 12'h7ff, 2'd3, 1'b0, 5'b00111, 12'h800, 2'd1};
    vecs[5] = '{5'b10101, 12'h123, 2'd0, 5'b10100, 12'h321, 2'd2, 1'b1, 5'b10101, 12'h123, 2'd0};
    init_pat = '{CMD_PREC, CMD_AREF, CMD_MRS, 5'b00111};

    RST_N = 1'b0; flag_init = 1'b0; init_cmd = CMD_MRS; init_addr = 12'h5a5;
    wr_req = 1'b0; wr_end = 1'b0; wr_cmd = CMD_NOP; wr_addr = '0; wr_ba = '0;
    rd_req = 1'b0; rd_end = 1'b0; rd_cmd = CMD_NOP; rd_addr = '0; rd_ba = '0;
    #2;
    chk("reset_state", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    step();
    step();
    RST_N = 1'b1;

    // INIT pass-through up to and including the cycle flag_init rises
    while (cyc <= 100) begin
      init_cmd  = init_pat[cyc % 4];
      init_addr = 12'(cyc * 37);
      if (cyc == 100) flag_init = 1'b1;
      chk("init_pass", mk(init_cmd, init_addr, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
      step();
    end
    t0 = cyc;
    flag_init = 1'b0;
    chk("arbit_nop", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);

    // First refresh: wrap 780 edges after the timer starts
    run_to(t0 + REF_PERIOD - 2);
    chk("pend_before_wrap", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    step();
    chk("pend_at_wrap", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), M_ALL);
    step();
    chk("first_aref", mk(CMD_AREF, 12'h400, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), M_ALL);
    step();
    chk("aref_step1", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    wr_req = 1'b1;
    rd_req = 1'b1;
    while (cyc < t0 + REF_PERIOD + T_RC) begin
      step();
      chk("no_grant_in_aref", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    end
    step();
    chk("wr_wins_tie", mk(CMD_NOP, 12'h000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), M_GNT);
    wr_req = 1'b0;
    apply_vecs(1'b1, "wr_vec");
    wr_end = 1'b1;
    chk("wr_end_cycle", mk(CMD_NOP, 12'h000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), M_GNT);
    step();
    wr_end = 1'b0;
    chk("after_wr_end", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    step();
    chk("rd_grant", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0), M_GNT);
    rd_req = 1'b0;
    apply_vecs(1'b0, "rd_vec");
    rd_end = 1'b1;
    step();
    rd_end = 1'b0;
    chk("after_rd_end", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);

    // Four bursts with both requests held high
    wr_req = 1'b1; wr_cmd = 5'b10100; wr_addr = 12'h0a1; wr_ba = 2'd1;
    rd_req = 1'b1; rd_cmd = 5'b10101; rd_addr = 12'h0b2; rd_ba = 2'd2;
    for (int b = 0; b < 4; b++) begin
`ifdef SDRAM_ARB_RR_EN
      exp_wr = (b % 2 == 0);
`else
      exp_wr = 1'b1;
`endif
      step();
      chk("tie_grant", mk(exp_wr ? wr_cmd : rd_cmd, exp_wr ? wr_addr : rd_addr,
                          exp_wr ? wr_ba : rd_ba, exp_wr, !exp_wr, 1'b0, 1'b0), M_PIN | M_GNT);
      step();
      chk("tie_hold", mk(CMD_NOP, 12'h000, 2'd0, exp_wr, !exp_wr, 1'b0, 1'b0), M_GNT);
      if (exp_wr) wr_end = 1'b1;
      else        rd_end = 1'b1;
      if (b == 3) begin
        wr_req = 1'b0;
        rd_req = 1'b0;
      end
      step();
      wr_end = 1'b0;
      rd_end = 1'b0;
      chk("tie_arbit", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    end

    // Refresh wraps mid-burst; AREF must precede the pending read
    run_to(t0 + 1530);
    wr_req = 1'b1; wr_cmd = 5'b10100; wr_addr = 12'h2c0; wr_ba = 2'd1;
    step();
    chk("wr2_grant", mk(5'b10100, 12'h2c0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0), M_ALL);
    wr_req = 1'b0;
    while (cyc < t0 + 1580) begin
      step();
      if (cyc == t0 + 1535) begin
        rd_req = 1'b1; rd_cmd = 5'b10101; rd_addr = 12'h0b2; rd_ba = 2'd2;
      end
      if (cyc == t0 + 1558)
        chk("wr2_pre_wrap", mk(5'b10100, 12'h2c0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0), M_ALL);
      if (cyc == t0 + 1559)
        chk("wr2_wrap_pend", mk(5'b10100, 12'h2c0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0), M_ALL);
    end
    wr_end = 1'b1;
    step();
    wr_end = 1'b0;
    chk("wr2_arbit", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), M_ALL);
    step();
    chk("aref_before_rd", mk(CMD_AREF, 12'h400, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), M_ALL);
    step();
    chk("pend_cleared", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    run_to(t0 + 1589);
    chk("rd_waits_trc", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    step();
    chk("rd_after_aref", mk(5'b10101, 12'h0b2, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0), M_ALL);
    rd_req = 1'b0;
    step();
    rd_end = 1'b1;
    step();
    rd_end = 1'b0;
    chk("rd2_done", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);

    // 1600-cycle write spanning two wraps; AREF step 0 then lands on the next wrap
    run_to(t0 + 2296);
    wr_req = 1'b1; wr_cmd = 5'b10011; wr_addr = 12'h0f0; wr_ba = 2'd3;
    step();
    chk("wr3_grant", mk(5'b10011, 12'h0f0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0), M_ALL);
    wr_req = 1'b0;
    while (cyc < t0 + 3896) begin
      step();
      if (cyc == t0 + 2338) chk("wr3_pre_wrap1", mk(CMD_NOP, 12'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_PEND | M_OVR);
      if (cyc == t0 + 2339) chk("wr3_wrap1", mk(CMD_NOP, 12'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), M_PEND | M_OVR);
      if (cyc == t0 + 3118) chk("wr3_pre_wrap2", mk(CMD_NOP, 12'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), M_PEND | M_OVR);
      if (cyc == t0 + 3119) chk("wr3_overrun", mk(5'b10011, 12'h0f0, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1), M_ALL);
    end
    wr_end = 1'b1;
    step();
    wr_end = 1'b0;
    chk("wr3_arbit", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1), M_ALL);
    step();
    chk("wr3_single_aref", mk(CMD_AREF, 12'h400, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1), M_ALL);
    while (cyc < t0 + 3960) begin
      step();
      chk("no_second_aref", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1), M_ALL);
    end

    // Reset in the middle of a read burst
    rd_req = 1'b1; rd_cmd = 5'b10101; rd_addr = 12'h0b2; rd_ba = 2'd2;
    step();
    chk("rd4_grant", mk(5'b10101, 12'h0b2, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1), M_ALL);
    rd_req = 1'b0;
    step();
    #2;
    RST_N = 1'b0;
    chk("reset_mid_read", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    step();
    step();
    RST_N = 1'b1;
    init_cmd = CMD_MRS; init_addr = 12'h123;
    chk("init_after_reset", mk(CMD_MRS, 12'h123, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    step();
    flag_init = 1'b1;
    step();
    t1 = cyc;
    flag_init = 1'b0;
    chk("arbit_after_reset", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    run_to(t1 + REF_PERIOD - 2);
    chk("cnt_restart_pre", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    step();
    chk("cnt_restart_wrap", mk(CMD_NOP, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), M_ALL);
    step();
    chk("cnt_restart_aref", mk(CMD_AREF, 12'h400, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), M_ALL);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
